// File: rtl/control_unit.sv
// control_unit: three-cycle fetch/decode/execute sequencer for the 4-bit CPU.
// Owns pc, instruction register, memory data register, accumulator and carry,
// drives the alu operands/opcode and the data memory write port.
module control_unit #(
  parameter int ALU_BIT_WIDTH        = 4,
  parameter int OPERATION_CODE_WIDTH = 3,
  parameter int PC_WIDTH             = 4,
  parameter int INSTR_WIDTH          = 8
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            en_i,
  output logic [PC_WIDTH-1:0]             pc_o,
  input  logic [INSTR_WIDTH-1:0]          instr_i,
  output logic [3:0]                      dmem_addr_o,
  input  logic [ALU_BIT_WIDTH-1:0]        dmem_rdata_i,
  output logic [ALU_BIT_WIDTH-1:0]        dmem_wdata_o,
  output logic                            dmem_we_o,
  output logic [ALU_BIT_WIDTH-1:0]        alu_a_o,
  output logic [ALU_BIT_WIDTH-1:0]        alu_b_o,
  output logic [OPERATION_CODE_WIDTH-1:0] alu_oc_o,
  input  logic [ALU_BIT_WIDTH-1:0]        alu_result_i,
  input  logic                            alu_carry_i,
  output logic [ALU_BIT_WIDTH-1:0]        acc_o,
  output logic                            carry_o,
  output logic                            halted_o
);

  typedef enum logic [1:0] {
    ST_FETCH   = 2'd0,
    ST_DECODE  = 2'd1,
    ST_EXECUTE = 2'd2,
    ST_HALT    = 2'd3
  } state_t;

  state_t                            state_r, state_nxt_s;
  logic [PC_WIDTH-1:0]               pc_r, pc_nxt_s;
  logic [INSTR_WIDTH-1:0]            ir_r, ir_nxt_s;
  logic [ALU_BIT_WIDTH-1:0]          mdr_r, mdr_nxt_s;
  logic [ALU_BIT_WIDTH-1:0]          acc_r, acc_nxt_s;
  logic                              carry_r, carry_nxt_s;
  logic [3:0]                        opcode_s;
  logic [3:0]                        operand_s;
  logic [OPERATION_CODE_WIDTH-1:0]   alu_oc_s;
  logic [ALU_BIT_WIDTH-1:0]          alu_b_s;
  logic                              dmem_we_s;

  assign opcode_s  = ir_r[7:4];
  assign operand_s = ir_r[3:0];

  // Next-state and register-update logic; every register holds unless its state writes it.
  always_comb begin
    state_nxt_s = state_r;
    pc_nxt_s    = pc_r;
    ir_nxt_s    = ir_r;
    mdr_nxt_s   = mdr_r;
    acc_nxt_s   = acc_r;
    carry_nxt_s = carry_r;
    case (state_r)
      ST_FETCH: begin
        ir_nxt_s    = instr_i;
        pc_nxt_s    = pc_r + PC_WIDTH'(1'b1);
        state_nxt_s = ST_DECODE;
      end
      ST_DECODE: begin
        mdr_nxt_s   = dmem_rdata_i;
        state_nxt_s = ST_EXECUTE;
      end
      ST_EXECUTE: begin
        state_nxt_s = ST_FETCH;
        if (!opcode_s[3]) begin
          // opcode 0000 is NOP; any other 0xxx is an alu operation
          if (opcode_s[2:0] != 3'b000) begin
            acc_nxt_s = alu_result_i;
            if (opcode_s[2]) begin
              carry_nxt_s = alu_carry_i;
            end else begin
              carry_nxt_s = carry_r;
            end
          end else begin
            acc_nxt_s = acc_r;
          end
        end else begin
          case (opcode_s)
            4'b1000: acc_nxt_s = mdr_r;
            4'b1010: pc_nxt_s  = PC_WIDTH'(operand_s);
            4'b1011: begin
              if (carry_r) begin
                pc_nxt_s = PC_WIDTH'(operand_s);
              end else begin
                pc_nxt_s = pc_r;
              end
            end
            4'b1100: acc_nxt_s   = ALU_BIT_WIDTH'(operand_s);
            4'b1111: state_nxt_s = ST_HALT;
            // STA only strobes the write port; 1101/1110 behave as NOP
            default: acc_nxt_s = acc_r;
          endcase
        end
      end
      ST_HALT: state_nxt_s = ST_HALT;
      default: state_nxt_s = ST_FETCH;
    endcase
  end

  // Alu operand/opcode selection and data memory write strobe.
  always_comb begin
    alu_oc_s  = {OPERATION_CODE_WIDTH{1'b0}};
    alu_b_s   = mdr_r;
    dmem_we_s = 1'b0;
    if (state_r == ST_EXECUTE) begin
      if (!opcode_s[3]) begin
        alu_oc_s = OPERATION_CODE_WIDTH'(opcode_s[2:0]);
        // increment/decrement forms use a constant 1 instead of memory
        if ((opcode_s[2:0] == 3'b101) || (opcode_s[2:0] == 3'b110)) begin
          alu_b_s = ALU_BIT_WIDTH'(1'b1);
        end else begin
          alu_b_s = mdr_r;
        end
      end else begin
        alu_oc_s = {OPERATION_CODE_WIDTH{1'b0}};
        alu_b_s  = mdr_r;
      end
      dmem_we_s = en_i && (opcode_s == 4'b1001);
    end else begin
      dmem_we_s = 1'b0;
    end
  end

  // Architectural registers; en_i low freezes everything, reset clears asynchronously.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= ST_FETCH;
      pc_r    <= {PC_WIDTH{1'b0}};
      ir_r    <= {INSTR_WIDTH{1'b0}};
      mdr_r   <= {ALU_BIT_WIDTH{1'b0}};
      acc_r   <= {ALU_BIT_WIDTH{1'b0}};
      carry_r <= 1'b0;
    end else if (en_i) begin
      state_r <= state_nxt_s;
      pc_r    <= pc_nxt_s;
      ir_r    <= ir_nxt_s;
      mdr_r   <= mdr_nxt_s;
      acc_r   <= acc_nxt_s;
      carry_r <= carry_nxt_s;
    end else begin
      state_r <= state_r;
      pc_r    <= pc_r;
      ir_r    <= ir_r;
      mdr_r   <= mdr_r;
      acc_r   <= acc_r;
      carry_r <= carry_r;
    end
  end

  assign pc_o         = pc_r;
  assign dmem_addr_o  = operand_s;
  assign dmem_wdata_o = acc_r;
  assign dmem_we_o    = dmem_we_s;
  assign alu_a_o      = acc_r;
  assign alu_b_o      = alu_b_s;
  assign alu_oc_o     = alu_oc_s;
  assign acc_o        = acc_r;
  assign carry_o      = carry_r;
  assign halted_o     = (state_r == ST_HALT);

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: drives control_unit with program/data memories and an alu,
// and checks it against an instruction-level model of the CPU.
module tb_control_unit;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       en_i;
  logic [3:0] pc_o;
  logic [7:0] instr_i;
  logic [3:0] dmem_addr_o;
  logic [3:0] dmem_rdata_i;
  logic [3:0] dmem_wdata_o;
  logic       dmem_we_o;
  logic [3:0] alu_a_o;
  logic [3:0] alu_b_o;
  logic [2:0] alu_oc_o;
  logic [3:0] alu_result_i;
  logic       alu_carry_i;
  logic [3:0] acc_o;
  logic       carry_o;
  logic       halted_o;

  control_unit dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .en_i(en_i), .pc_o(pc_o), .instr_i(instr_i),
    .dmem_addr_o(dmem_addr_o), .dmem_rdata_i(dmem_rdata_i), .dmem_wdata_o(dmem_wdata_o),
    .dmem_we_o(dmem_we_o), .alu_a_o(alu_a_o), .alu_b_o(alu_b_o), .alu_oc_o(alu_oc_o),
    .alu_result_i(alu_result_i), .alu_carry_i(alu_carry_i), .acc_o(acc_o),
    .carry_o(carry_o), .halted_o(halted_o)
  );

  always #5 clk_i = ~clk_i;

  logic [7:0] prog [16];
  logic [3:0] dmem [16];

  assign instr_i      = prog[pc_o];
  assign dmem_rdata_i = dmem[dmem_addr_o];

  // alu: 001 XOR, 010 AND, 011 OR, 1x0/1x1 add or subtract; result {carry, value}
  function automatic logic [4:0] alu_fn(input logic [2:0] oc, input logic [3:0] a, input logic [3:0] b);
    case (oc)
      3'b001:  return {1'b0, a ^ b};
      3'b010:  return {1'b0, a & b};
      3'b011:  return {1'b0, a | b};
      3'b100, 3'b101: return {1'b0, a} + {1'b0, b};
      3'b110, 3'b111: return {1'b0, a} - {1'b0, b};
      default: return {1'b0, a};
    endcase
  endfunction

  always_comb {alu_carry_i, alu_result_i} = alu_fn(alu_oc_o, alu_a_o, alu_b_o);

  int total = 0;
  int bad   = 0;

  logic [3:0] m_pc, m_acc;
  logic       m_carry, m_halted;
  logic [3:0] m_dmem [16];

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // one clock: perform any memory write at the negedge, then sample after the posedge
  task automatic step();
    @(negedge clk_i);
    if (dmem_we_o === 1'b1) dmem[dmem_addr_o] = dmem_wdata_o;
    @(posedge clk_i);
    #1;
  endtask

  task automatic clr_mem();
    for (int i = 0; i < 16; i++) begin
      prog[i]   = 8'h00;
      dmem[i]   = 4'h0;
      m_dmem[i] = 4'h0;
    end
  endtask

  task automatic do_reset();
    rst_ni   = 1'b0;
    en_i     = 1'b1;
    m_pc     = 4'h0;
    m_acc    = 4'h0;
    m_carry  = 1'b0;
    m_halted = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_pc",     8'(pc_o),        8'h00);
    chk("rst_acc",    8'(acc_o),       8'h00);
    chk("rst_carry",  8'(carry_o),     8'h00);
    chk("rst_halted", 8'(halted_o),    8'h00);
    chk("rst_we",     8'(dmem_we_o),   8'h00);
    chk("rst_oc",     8'(alu_oc_o),    8'h00);
    chk("rst_b",      8'(alu_b_o),     8'h00);
    chk("rst_addr",   8'(dmem_addr_o), 8'h00);
    rst_ni = 1'b1;
  endtask

  // execute one instruction on the model and check the DUT through its three cycles
  task automatic run_instr(input int stall);
    logic [7:0] ins;
    logic [3:0] op, arg, mval, bval;
    logic [2:0] exp_oc;
    logic [4:0] res;
    if (m_halted) begin
      step();
      chk("hlt_halted", 8'(halted_o),  8'h01);
      chk("hlt_pc",     8'(pc_o),      8'(m_pc));
      chk("hlt_we",     8'(dmem_we_o), 8'h00);
      chk("hlt_acc",    8'(acc_o),     8'(m_acc));
      return;
    end
    ins  = prog[m_pc];
    op   = ins[7:4];
    arg  = ins[3:0];
    step();
    m_pc = m_pc + 4'h1;
    chk("dec_pc",   8'(pc_o),        8'(m_pc));
    chk("dec_addr", 8'(dmem_addr_o), 8'(arg));
    if (stall > 0) begin
      en_i = 1'b0;
      for (int s = 0; s < stall; s++) begin
        step();
        chk("stall_pc",    8'(pc_o),        8'(m_pc));
        chk("stall_acc",   8'(acc_o),       8'(m_acc));
        chk("stall_carry", 8'(carry_o),     8'(m_carry));
        chk("stall_addr",  8'(dmem_addr_o), 8'(arg));
        chk("stall_we",    8'(dmem_we_o),   8'h00);
        chk("stall_oc",    8'(alu_oc_o),    8'h00);
      end
      en_i = 1'b1;
    end
    mval = m_dmem[arg];
    step();
    exp_oc = op[3] ? 3'b000 : op[2:0];
    bval   = (!op[3] && (op[2:0] == 3'b101 || op[2:0] == 3'b110)) ? 4'h1 : mval;
    chk("exe_oc",   8'(alu_oc_o),    8'(exp_oc));
    chk("exe_b",    8'(alu_b_o),     8'(bval));
    chk("exe_a",    8'(alu_a_o),     8'(m_acc));
    chk("exe_addr", 8'(dmem_addr_o), 8'(arg));
    chk("exe_we",   8'(dmem_we_o),   (op == 4'h9) ? 8'h01 : 8'h00);
    if (op == 4'h9) chk("exe_wdata", 8'(dmem_wdata_o), 8'(m_acc));
    if (!op[3] && op[2:0] != 3'b000) begin
      res   = alu_fn(op[2:0], m_acc, bval);
      m_acc = res[3:0];
      if (op[2]) m_carry = res[4];
    end else begin
      case (op)
        4'h8: m_acc = mval;
        4'h9: m_dmem[arg] = m_acc;
        4'hA: m_pc = arg;
        4'hB: if (m_carry) m_pc = arg;
        4'hC: m_acc = arg;
        4'hF: m_halted = 1'b1;
        default: ;
      endcase
    end
    step();
    chk("post_acc",    8'(acc_o),    8'(m_acc));
    chk("post_carry",  8'(carry_o),  8'(m_carry));
    chk("post_pc",     8'(pc_o),     8'(m_pc));
    chk("post_halted", 8'(halted_o), 8'(m_halted));
  endtask

  task automatic run_to_halt();
    for (int k = 0; k < 30 && !m_halted; k++) run_instr(0);
    chk("reached_halt", 8'(halted_o), 8'h01);
  endtask

  initial begin
    rst_ni = 1'b0;
    en_i   = 1'b1;

    // LDI 2; HLT, then confirm HALT is absorbing
    clr_mem();
    prog[0] = 8'hC2; prog[1] = 8'hF0;
    do_reset();
    run_to_halt();
    run_instr(0);
    run_instr(0);
    chk("hlt_pc_hold", 8'(pc_o), 8'h02);
    chk("hlt_acc2",    8'(acc_o), 8'h02);

    // ADD mem, ADD 1, XOR keeps carry, JC taken then JC not taken
    clr_mem();
    dmem[0] = 4'hF; m_dmem[0] = 4'hF;
    dmem[1] = 4'hA; m_dmem[1] = 4'hA;
    prog[0] = 8'hC2; prog[1] = 8'h40; prog[2] = 8'hCF; prog[3] = 8'h50;
    prog[4] = 8'h11; prog[5] = 8'hB7; prog[7] = 8'h50; prog[8] = 8'hB7;
    prog[9] = 8'hF0;
    do_reset();
    run_to_halt();
    chk("jc_final_pc", 8'(pc_o), 8'h0A);

    // LDI 9; STA 3; LDI 0; LDA 3
    clr_mem();
    prog[0] = 8'hC9; prog[1] = 8'h93; prog[2] = 8'hC0; prog[3] = 8'h83; prog[4] = 8'hF0;
    do_reset();
    run_to_halt();
    chk("sta_mem3", 8'(dmem[3]), 8'(m_dmem[3]));
    chk("lda_acc",  8'(acc_o),   8'h09);

    // JMP 0 at pc 15, and linear wrap 15 -> 0
    clr_mem();
    prog[0] = 8'hAF; prog[15] = 8'hA0;
    do_reset();
    for (int k = 0; k < 3; k++) run_instr(0);
    clr_mem();
    prog[0] = 8'hAE;
    do_reset();
    for (int k = 0; k < 4; k++) run_instr(0);

    // five frozen cycles in DECODE
    clr_mem();
    dmem[1] = 4'h3; m_dmem[1] = 4'h3;
    prog[0] = 8'hC5; prog[1] = 8'h51; prog[2] = 8'h11; prog[3] = 8'hF0;
    do_reset();
    run_instr(0);
    run_instr(5);
    run_to_halt();

    // reset asserted during STA EXECUTE aborts the write
    clr_mem();
    dmem[3] = 4'h6; m_dmem[3] = 4'h6;
    prog[0] = 8'hC9; prog[1] = 8'h93;
    do_reset();
    run_instr(0);
    step();
    step();
    chk("sta_we_before", 8'(dmem_we_o), 8'h01);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("rst_sta_we",  8'(dmem_we_o), 8'h00);
    chk("rst_sta_acc", 8'(acc_o),     8'h00);
    chk("rst_sta_pc",  8'(pc_o),      8'h00);
    step();
    chk("rst_sta_mem", 8'(dmem[3]), 8'h06);

    // random programs and data
    for (int r = 0; r < 4; r++) begin
      clr_mem();
      for (int i = 0; i < 16; i++) begin
        prog[i]   = 8'($urandom_range(0, 255));
        dmem[i]   = 4'($urandom_range(0, 15));
        m_dmem[i] = dmem[i];
      end
      do_reset();
      for (int k = 0; k < 40; k++) run_instr((k == 7) ? 2 : 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
Multi-cycle fetch/decode/execute sequencer for the 4-bit CPU, directly upstream of the alu.
- Fetches 8-bit instructions from program memory and holds the accumulator and carry flag.
- Drives the alu operands and opcode, then writes back alu result/carry.
- Handles loads, stores, jumps and halt against a small data memory.

Parameters:
ALU_BIT_WIDTH, 4, datapath/accumulator width
OPERATION_CODE_WIDTH, 3, alu opcode width
PC_WIDTH, 4, program counter width (16 instructions)
INSTR_WIDTH, 8, instruction word: [7:4] opcode, [3:0] operand (address or immediate)

Ports:
clk_i  in  1  clock, rising edge
rst_ni  in  1  asynchronous active-low reset
en_i  in  1  run enable; low freezes the FSM and all registers
pc_o  out  PC_WIDTH  program memory address
instr_i  in  INSTR_WIDTH  program memory data, combinational from pc_o
dmem_addr_o  out  4  data memory address (= IR[3:0])
dmem_rdata_i  in  ALU_BIT_WIDTH  data memory read data, combinational
dmem_wdata_o  out  ALU_BIT_WIDTH  data memory write data (= accumulator)
dmem_we_o  out  1  data memory write strobe, one cycle
alu_a_o  out  ALU_BIT_WIDTH  alu operand a (= accumulator)
alu_b_o  out  ALU_BIT_WIDTH  alu operand b (MDR, or constant 1)
alu_oc_o  out  OPERATION_CODE_WIDTH  alu operation code
alu_result_i  in  ALU_BIT_WIDTH  alu result
alu_carry_i  in  1  alu carry
acc_o  out  ALU_BIT_WIDTH  accumulator
carry_o  out  1  carry flag
halted_o  out  1  high in HALT

Behaviour:
- Reset (async, rst_ni=0):
  - pc=0, IR=0, MDR=0, acc=0, carry=0, state=FETCH.
  - dmem_we_o=0, halted_o=0 immediately; all outputs derived from these registers.
  - Reset during EXECUTE of STA aborts the write; no partial state is retained.
- FSM states: FETCH -> DECODE -> EXECUTE -> FETCH; HALT is absorbing. Each instruction takes 3 enabled cycles.
- en_i=0: no register or state changes, dmem_we_o forced 0; execution resumes where it stopped.
- FETCH: IR <= instr_i at pc_o; pc <= pc+1, wrapping 15->0.
- DECODE: dmem_addr_o=IR[3:0]; MDR <= dmem_rdata_i, for every opcode.
- EXECUTE, by IR[7:4]:
  - 0000 NOP: no change.
  - 0xxx, xxx != 000 (ALU op): alu_oc_o=xxx, alu_a_o=acc.
    - alu_b_o = 1 for xxx=101 (ADD 1) or 110 (SUB 1); otherwise MDR.
    - acc <= alu_result_i.
    - carry <= alu_carry_i only when xxx[2]=1 (ADD/SUB); XOR/AND/OR leave carry unchanged.
  - 1000 LDA: acc <= MDR; carry unchanged.
  - 1001 STA: dmem_we_o=1 for exactly this cycle; dmem_addr_o=IR[3:0], dmem_wdata_o=acc.
  - 1010 JMP: pc <= IR[3:0].
  - 1011 JC: pc <= IR[3:0] if carry=1, else pc unchanged (already incremented).
  - 1100 LDI: acc <= IR[3:0].
  - 1111 HLT: state <= HALT.
  - 1101, 1110: treated as NOP.
- HALT: halted_o=1; no further fetches; pc holds address after HLT. Exit only by reset.
- Outside EXECUTE:
  - alu_oc_o=000 and alu_b_o=MDR.
  - alu_a_o always equals acc.
  - acc/carry are only written in EXECUTE.
- All arithmetic is modulo 2^ALU_BIT_WIDTH. The pc jump target is zero-extended IR[3:0].
- dmem_addr_o = IR[3:0] in every state.

Test Plan:
- Reset then LDI 2 (0xC2), HLT (0xF0):
  - acc_o=2 after 3 enabled cycles.
  - halted_o=1 after 6 cycles.
  - pc_o holds 2; dmem_we_o never 1.
- mem[0]=F, program LDI 2; ADD mem (0x40); HLT -> acc=1, carry=1 after the ADD EXECUTE; alu_oc_o=100 and alu_b_o=F observed in that cycle.
- ADD 1 with acc=F (0x50) -> alu_b_o=1, acc=0, carry=1.
- Carry behaviour:
  - Follow with XOR mem (0x10, mem=A) -> acc=A, carry stays 1.
  - Then JC 7 (0xB7) -> pc_o=7 at next FETCH.
  - With carry=0, JC 7 falls through to pc+1.
- LDI 9; STA 3 (0x93):
  - dmem_we_o=1 for exactly one cycle with dmem_addr_o=3, dmem_wdata_o=9.
  - Then LDA 3 (0x83) after LDI 0 -> acc=9.
- Edge cases:
  - JMP 0 placed at pc=15 -> wrap/jump to 0.
  - Linear fetch at pc=15 -> pc_o becomes 0.
  - en_i=0 for 5 cycles mid-DECODE freezes all outputs.
  - Asserting rst_ni=0 during STA EXECUTE drops dmem_we_o asynchronously, and acc/pc read 0.
